// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_pkg
//  Description : Shared tag/state/entry types for the reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

    localparam int TAG_W = 6;

    // Tag value meaning "not redirected": the register holds a real value.
    localparam logic [TAG_W-1:0] NOT_REDIRECTED = '0;

    // Widest opcode an entry can hold; the top-level OP_W must not exceed it.
    localparam int OP_W_MAX = 8;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAITING   = 2'd1,
        READY     = 2'd2,
        EXECUTING = 2'd3
    } rs_state_t;

    // A pending operand keeps its producer tag in the low TAG_W bits.
    typedef struct packed {
        rs_state_t           state;
        logic [OP_W_MAX-1:0] op;
        logic [31:0]         a;
        logic                a_invalid;
        logic [31:0]         b;
        logic                b_invalid;
    } rs_entry_t;

    // True when a live broadcast resolves this pending operand.
    function automatic logic snoop_hit(input logic             cdb_live,
                                       input logic [TAG_W-1:0] cdb_tag,
                                       input logic             opnd_invalid,
                                       input logic [31:0]      opnd);
        return cdb_live && opnd_invalid && (opnd[TAG_W-1:0] == cdb_tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
//  Module      : rs_entry
//  Description : One reservation-station entry: state register, operand
//                capture with same-edge CDB bypass, CDB snoop and self-free.
//  Revision    : 1.0 - initial release
// ============================================================================
import tomasulo_pkg::*;

module rs_entry #(
    parameter logic [TAG_W-1:0] MY_TAG = 6'd1,
    parameter int               OP_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [31:0]      a_value_i,
    input  logic             a_invalid_i,
    input  logic [31:0]      b_value_i,
    input  logic             b_invalid_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_data_i,
    input  logic             dispatch_i,
    output rs_state_t        state_o,
    output logic [OP_W-1:0]  op_o,
    output logic [31:0]      a_o,
    output logic [31:0]      b_o
);

    rs_entry_t entry_q;
    rs_entry_t entry_d;
    logic      w_cdb_live;

    // Next-state: allocate, snoop pending operands, dispatch, free on own tag.
    always_comb begin
        entry_d    = entry_q;
        w_cdb_live = cdb_valid_i && (cdb_tag_i != NOT_REDIRECTED);
        case (entry_q.state)
            EMPTY: begin
                if (alloc_i) begin
                    entry_d.op        = OP_W_MAX'(op_i);
                    entry_d.a         = a_value_i;
                    entry_d.a_invalid = a_invalid_i;
                    entry_d.b         = b_value_i;
                    entry_d.b_invalid = b_invalid_i;
                    // Producer broadcasting on this very edge: take its data now.
                    if (snoop_hit(w_cdb_live, cdb_tag_i, a_invalid_i, a_value_i)) begin
                        entry_d.a         = cdb_data_i;
                        entry_d.a_invalid = 1'b0;
                    end
                    if (snoop_hit(w_cdb_live, cdb_tag_i, b_invalid_i, b_value_i)) begin
                        entry_d.b         = cdb_data_i;
                        entry_d.b_invalid = 1'b0;
                    end
                    entry_d.state = (entry_d.a_invalid || entry_d.b_invalid) ? WAITING : READY;
                end
            end
            WAITING: begin
                if (snoop_hit(w_cdb_live, cdb_tag_i, entry_q.a_invalid, entry_q.a)) begin
                    entry_d.a         = cdb_data_i;
                    entry_d.a_invalid = 1'b0;
                end
                if (snoop_hit(w_cdb_live, cdb_tag_i, entry_q.b_invalid, entry_q.b)) begin
                    entry_d.b         = cdb_data_i;
                    entry_d.b_invalid = 1'b0;
                end
                if (!entry_d.a_invalid && !entry_d.b_invalid) begin
                    entry_d.state = READY;
                end
            end
            READY: begin
                if (dispatch_i) begin
                    entry_d.state = EXECUTING;
                end
            end
            EXECUTING: begin
                if (w_cdb_live && (cdb_tag_i == MY_TAG)) begin
                    entry_d.state = EMPTY;
                end
            end
            default: entry_d.state = EMPTY;
        endcase
    end

    // Entry register; reset empties the entry and zeroes its operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign state_o = entry_q.state;
    assign op_o    = entry_q.op[OP_W-1:0];
    assign a_o     = entry_q.a;
    assign b_o     = entry_q.b;

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station
//  Description : Bank of reservation-station entries for one functional unit:
//                lowest-index allocator, lowest-index READY dispatch selector
//                and a lock that holds the presented entry until handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
import tomasulo_pkg::*;

module reservation_station #(
    parameter int NUM_ENTRIES = 4,   // 1..8
    parameter int TAG_BASE    = 1,   // nonzero; TAG_BASE+NUM_ENTRIES-1 <= 63
    parameter int OP_W        = 3    // <= OP_W_MAX
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic [OP_W-1:0]  op,
    input  logic [31:0]      A_value,
    input  logic             A_invalid,
    input  logic [31:0]      B_value,
    input  logic             B_invalid,
    output logic [TAG_W-1:0] free_tag,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             dispatch_valid,
    input  logic             dispatch_ready,
    output logic [OP_W-1:0]  dispatch_op,
    output logic [31:0]      dispatch_a,
    output logic [31:0]      dispatch_b,
    output logic [TAG_W-1:0] dispatch_tag
);

    rs_state_t              w_state [NUM_ENTRIES];
    logic [OP_W-1:0]        w_op    [NUM_ENTRIES];
    logic [31:0]            w_a     [NUM_ENTRIES];
    logic [31:0]            w_b     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_alloc;
    logic [NUM_ENTRIES-1:0] w_dispatch;

    logic       w_any_empty;
    logic [2:0] w_free_idx;
    logic       w_any_ready;
    logic [2:0] w_ready_idx;
    logic [2:0] w_sel_idx;
    logic       w_fire;

    logic       lock_q;
    logic       lock_d;
    logic [2:0] lock_idx_q;
    logic [2:0] lock_idx_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            rs_entry #(
                .MY_TAG (TAG_W'(TAG_BASE + gi)),
                .OP_W   (OP_W)
            ) u_entry (
                .clk_i       (clock),
                .rst_i       (reset),
                .alloc_i     (w_alloc[gi]),
                .op_i        (op),
                .a_value_i   (A_value),
                .a_invalid_i (A_invalid),
                .b_value_i   (B_value),
                .b_invalid_i (B_invalid),
                .cdb_valid_i (cdb_valid),
                .cdb_tag_i   (cdb_tag),
                .cdb_data_i  (cdb_data),
                .dispatch_i  (w_dispatch[gi]),
                .state_o     (w_state[gi]),
                .op_o        (w_op[gi]),
                .a_o         (w_a[gi]),
                .b_o         (w_b[gi])
            );
        end
    endgenerate

    // Allocator: lowest-index EMPTY entry; index stays 0 when full so free_tag=TAG_BASE.
    always_comb begin
        w_any_empty = 1'b0;
        w_free_idx  = 3'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_state[i] == EMPTY) begin
                w_any_empty = 1'b1;
                w_free_idx  = 3'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_alloc[i] = issue && w_any_empty && (w_free_idx == 3'(i));
        end
        full     = !w_any_empty;
        free_tag = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
    end

    // Dispatch selector: locked entry wins, otherwise lowest-index READY entry.
    always_comb begin
        w_any_ready = 1'b0;
        w_ready_idx = 3'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_state[i] == READY) begin
                w_any_ready = 1'b1;
                w_ready_idx = 3'(i);
            end
        end
        w_sel_idx      = lock_q ? lock_idx_q : w_ready_idx;
        dispatch_valid = lock_q || w_any_ready;
        w_fire         = dispatch_valid && dispatch_ready;
        dispatch_op    = '0;
        dispatch_a     = '0;
        dispatch_b     = '0;
        dispatch_tag   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_dispatch[i] = w_fire && (w_sel_idx == 3'(i));
            if (dispatch_valid && (w_sel_idx == 3'(i))) begin
                dispatch_op  = w_op[i];
                dispatch_a   = w_a[i];
                dispatch_b   = w_b[i];
                dispatch_tag = TAG_W'(TAG_BASE + i);
            end
        end
    end

    // Lock next-state: engage while presented but not accepted, release on handshake.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (w_fire) begin
            lock_d = 1'b0;
        end else if (dispatch_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = w_sel_idx;
        end
    end

    // Lock register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 3'd0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_station
//  Description : Directed self-checking bench for reservation_station
//                (4 entries, tags 1..4, 3-bit opcode).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    logic        clock;
    logic        reset;
    logic        issue;
    logic [2:0]  op;
    logic [31:0] A_value;
    logic        A_invalid;
    logic [31:0] B_value;
    logic        B_invalid;
    logic [5:0]  free_tag;
    logic        full;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [2:0]  dispatch_op;
    logic [31:0] dispatch_a;
    logic [31:0] dispatch_b;
    logic [5:0]  dispatch_tag;

    int n_checks = 0;
    int n_errors = 0;

    reservation_station #(
        .NUM_ENTRIES (4),
        .TAG_BASE    (1),
        .OP_W        (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .issue          (issue),
        .op             (op),
        .A_value        (A_value),
        .A_invalid      (A_invalid),
        .B_value        (B_value),
        .B_invalid      (B_invalid),
        .free_tag       (free_tag),
        .full           (full),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_op    (dispatch_op),
        .dispatch_a     (dispatch_a),
        .dispatch_b     (dispatch_b),
        .dispatch_tag   (dispatch_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check in the bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic ai,
                            input logic [31:0] b, input logic bi);
        issue     = 1'b1;
        op        = o;
        A_value   = a;
        A_invalid = ai;
        B_value   = b;
        B_invalid = bi;
        tick();
        issue     = 1'b0;
        A_invalid = 1'b0;
        B_invalid = 1'b0;
    endtask

    task automatic bcast(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
        cdb_tag   = 6'd0;
        cdb_data  = 32'd0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_dv"}, dispatch_valid, 0);
        chk({tag, "_free"}, free_tag, 1);
        chk({tag, "_op"}, dispatch_op, 0);
        chk({tag, "_a"}, dispatch_a, 0);
        chk({tag, "_b"}, dispatch_b, 0);
        chk({tag, "_tag"}, dispatch_tag, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; issue = 1'b0; op = '0; A_value = '0; A_invalid = 1'b0;
        B_value = '0; B_invalid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
        cdb_data = '0; dispatch_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_idle("rst");

        // Basic issue, hold, handshake, free.
        issue_op(3'd2, 32'd5, 1'b0, 32'd7, 1'b0);
        chk("t1_free", free_tag, 2);
        chk("t1_dv", dispatch_valid, 1);
        chk("t1_op", dispatch_op, 2);
        chk("t1_a", dispatch_a, 5);
        chk("t1_b", dispatch_b, 7);
        chk("t1_tag", dispatch_tag, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_hold_dv", dispatch_valid, 1);
            chk("t1_hold_a", dispatch_a, 5);
            chk("t1_hold_tag", dispatch_tag, 1);
        end
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        chk("t1_exec_dv", dispatch_valid, 0);
        chk("t1_exec_free", free_tag, 2);
        bcast(6'd1, 32'h1234);
        chk("t1_freed", free_tag, 1);

        // Pending A operand resolved by a later broadcast.
        issue_op(3'd1, 32'd3, 1'b1, 32'd9, 1'b0);
        chk("t2_wait_dv", dispatch_valid, 0);
        chk("t2_wait_free", free_tag, 2);
        bcast(6'd3, 32'hDEAD);
        chk("t2_dv", dispatch_valid, 1);
        chk("t2_a", dispatch_a, 32'hDEAD);
        chk("t2_b", dispatch_b, 9);
        chk("t2_tag", dispatch_tag, 1);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        bcast(6'd1, 32'h0);

        // Same-edge bypass of a pending B operand.
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h55;
        issue_op(3'd4, 32'h11, 1'b0, 32'd2, 1'b1);
        cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_data = 32'd0;
        chk("t3_dv", dispatch_valid, 1);
        chk("t3_b", dispatch_b, 32'h55);
        chk("t3_a", dispatch_a, 32'h11);
        chk("t3_op", dispatch_op, 4);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        bcast(6'd1, 32'h0);
        chk("t3_clean_free", free_tag, 1);

        // Fill all entries, ignored fifth issue, free entry 2.
        for (int i = 0; i < 4; i++) begin
            issue_op(3'(i), 32'h100 + i, 1'b0, 32'h200 + i, 1'b0);
        end
        chk("t4_full", full, 1);
        chk("t4_full_free", free_tag, 1);
        issue_op(3'd7, 32'hBAD, 1'b0, 32'hBAD, 1'b0);
        chk("t4_ign_full", full, 1);
        chk("t4_ign_tag", dispatch_tag, 1);
        chk("t4_ign_a", dispatch_a, 32'h100);
        dispatch_ready = 1'b1;
        tick();
        chk("t4_d1_tag", dispatch_tag, 2);
        chk("t4_d1_a", dispatch_a, 32'h101);
        tick();
        chk("t4_d2_tag", dispatch_tag, 3);
        chk("t4_d2_b", dispatch_b, 32'h202);
        tick();
        dispatch_ready = 1'b0;
        chk("t4_d3_tag", dispatch_tag, 4);
        chk("t4_d3_op", dispatch_op, 3);
        bcast(6'd3, 32'h0);
        chk("t4_free_full", full, 0);
        chk("t4_free_tag", free_tag, 3);
        chk("t4_free_dtag", dispatch_tag, 4);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        bcast(6'd1, 32'h0);
        bcast(6'd2, 32'h0);
        bcast(6'd4, 32'h0);
        chk_idle("t4_drain");

        // Lock holds entry 1 while entry 0 becomes READY.
        issue_op(3'd3, 32'd5, 1'b1, 32'd1, 1'b0);
        issue_op(3'd5, 32'h22, 1'b0, 32'h33, 1'b0);
        chk("t5_pres_tag", dispatch_tag, 2);
        chk("t5_pres_a", dispatch_a, 32'h22);
        bcast(6'd5, 32'h77);
        chk("t5_lock_tag", dispatch_tag, 2);
        chk("t5_lock_a", dispatch_a, 32'h22);
        tick();
        chk("t5_lock2_tag", dispatch_tag, 2);
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        chk("t5_next_tag", dispatch_tag, 1);
        chk("t5_next_a", dispatch_a, 32'h77);
        chk("t5_next_b", dispatch_b, 1);
        chk("t5_next_op", dispatch_op, 3);

        // Reset with three busy entries.
        chk("t6_pre_free", free_tag, 3);
        issue_op(3'd6, 32'h9, 1'b0, 32'h8, 1'b0);
        chk("t6_busy_free", free_tag, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("t6_rst");
        issue_op(3'd1, 32'h9, 1'b0, 32'h8, 1'b0);
        chk("t6_post_tag", dispatch_tag, 1);
        chk("t6_post_a", dispatch_a, 32'h9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
